// File: rtl/logic_vector_checker_if.sv
// Bus between the vector checker and the gate under test: run control,
// stimulus vector, the gate's response and the result/status outputs.
interface logic_vector_checker_if #(
   parameter int N_IN  = 4,
   parameter int CNT_W = 16
);
   logic              start;
   logic              dut_out;
   logic [N_IN-1:0]   vec_out;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  err_cnt;
   logic              first_err_vld;
   logic [N_IN-1:0]   first_err_vec;

   // Checker side: drives stimulus and results, observes start and the gate.
   modport master (
      input  start,
      input  dut_out,
      output vec_out,
      output busy,
      output done,
      output err_cnt,
      output first_err_vld,
      output first_err_vec
   );

   // Bench/gate side: requests runs, answers the stimulus, reads results.
   modport slave (
      output start,
      output dut_out,
      input  vec_out,
      input  busy,
      input  done,
      input  err_cnt,
      input  first_err_vld,
      input  first_err_vec
   );
endinterface

// File: rtl/logic_vector_checker.sv
// Exhaustive stimulus engine for an N_IN-input reduction gate. Walks every input
// combination, holds each for DWELL clocks, compares the gate output with a
// reference function on the last dwell clock, counts mismatches (saturating)
// and remembers the first failing vector.
module logic_vector_checker #(
   parameter int N_IN  = 4,
   parameter int DWELL = 5,
   parameter int MODE  = 0,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   logic_vector_checker_if.master  bus
);

   localparam int MODE_NOR  = 32'sd0;
   localparam int MODE_OR   = 32'sd1;
   localparam int MODE_AND  = 32'sd2;
   localparam int MODE_NAND = 32'sd3;

   // Dwell counter only needs to reach DWELL-1; keep at least one bit.
   localparam int             DW         = (DWELL > 32'sd1) ? $clog2(DWELL) : 32'sd1;
   localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL - 32'sd1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Reference model of the gate under test.
   function automatic logic ref_fn(input logic [N_IN-1:0] v);
      logic r;
      case (MODE)
         MODE_NOR:  r = ~|v;
         MODE_OR:   r =  |v;
         MODE_AND:  r =  &v;
         MODE_NAND: r = ~&v;
         default:   r = 1'b0;
      endcase
      return r;
   endfunction

   state_t             state_r;
   state_t             next_state_s;
   logic               busy_r;
   logic               done_r;
   logic               busy_nxt_s;
   logic               done_nxt_s;

   logic [N_IN-1:0]    vec_r;
   logic [DW-1:0]      dwell_r;
   logic [CNT_W-1:0]   err_r;
   logic               fvld_r;
   logic [N_IN-1:0]    fvec_r;

   logic               launch_s;
   logic               check_edge_s;
   logic               last_vec_s;
   logic               mismatch_s;

   // Decode run launch, check edges and mismatches from the current registers.
   always_comb begin
      launch_s     = 1'b0;
      check_edge_s = 1'b0;
      mismatch_s   = 1'b0;
      last_vec_s   = (vec_r == {N_IN{1'b1}});
      if ((state_r == IDLE) || (state_r == DONE)) begin
         launch_s = bus.start;
      end else begin
         launch_s = 1'b0;
      end
      if ((state_r == RUN) && (dwell_r == DWELL_LAST)) begin
         check_edge_s = 1'b1;
         mismatch_s   = (bus.dut_out != ref_fn(vec_r));
      end else begin
         check_edge_s = 1'b0;
         mismatch_s   = 1'b0;
      end
   end

   // State register; busy/done are registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= busy_nxt_s;
         done_r  <= done_nxt_s;
      end
   end

   // Next-state logic: start only matters outside RUN; the last check edge ends the run.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE, DONE: begin
            if (launch_s) begin
               next_state_s = RUN;
            end else begin
               next_state_s = state_r;
            end
         end
         RUN: begin
            if (check_edge_s && last_vec_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = RUN;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Status outputs follow the state being entered.
   always_comb begin
      busy_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
      case (next_state_s)
         RUN:     busy_nxt_s = 1'b1;
         DONE:    done_nxt_s = 1'b1;
         default: begin
            busy_nxt_s = 1'b0;
            done_nxt_s = 1'b0;
         end
      endcase
   end

   // Stimulus vector, dwell timing, error counter and first-failure capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_r   <= {N_IN{1'b0}};
         dwell_r <= {DW{1'b0}};
         err_r   <= {CNT_W{1'b0}};
         fvld_r  <= 1'b0;
         fvec_r  <= {N_IN{1'b0}};
      end else if (launch_s) begin
         vec_r   <= {N_IN{1'b0}};
         dwell_r <= {DW{1'b0}};
         err_r   <= {CNT_W{1'b0}};
         fvld_r  <= 1'b0;
         fvec_r  <= {N_IN{1'b0}};
      end else if (state_r == RUN) begin
         if (!check_edge_s) begin
            dwell_r <= dwell_r + DW'(1'b1);
         end else begin
            if (mismatch_s) begin
               if (err_r != {CNT_W{1'b1}}) begin
                  err_r <= err_r + CNT_W'(1'b1);
               end
               if (!fvld_r) begin
                  fvld_r <= 1'b1;
                  fvec_r <= vec_r;
               end
            end
            dwell_r <= {DW{1'b0}};
            // The all-ones vector is held into DONE.
            if (!last_vec_s) begin
               vec_r <= vec_r + N_IN'(1'b1);
            end
         end
      end
   end

   assign bus.vec_out       = vec_r;
   assign bus.busy          = busy_r;
   assign bus.done          = done_r;
   assign bus.err_cnt       = err_r;
   assign bus.first_err_vld = fvld_r;
   assign bus.first_err_vec = fvec_r;

endmodule

// File: tb/tb_logic_vector_checker.sv
// Directed bench for logic_vector_checker: NOR, AND, NAND and a saturating
// DWELL=1 instance, each fed by a behavioural gate with selectable stuck faults.
module tb_logic_vector_checker;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   cyc;

   // Gate behaviour per instance: 0 = correct, 1 = stuck-0, 2 = stuck-1
   logic [1:0] f0, f2, fs, f3;

   logic_vector_checker_if #(.N_IN(4), .CNT_W(16)) bus0 ();
   logic_vector_checker_if #(.N_IN(4), .CNT_W(16)) bus2 ();
   logic_vector_checker_if #(.N_IN(4), .CNT_W(2))  buss ();
   logic_vector_checker_if #(.N_IN(2), .CNT_W(4))  bus3 ();

   logic_vector_checker #(.N_IN(4), .DWELL(5), .MODE(0), .CNT_W(16)) u_nor  (.clk(clk), .rst(rst), .bus(bus0));
   logic_vector_checker #(.N_IN(4), .DWELL(5), .MODE(2), .CNT_W(16)) u_and  (.clk(clk), .rst(rst), .bus(bus2));
   logic_vector_checker #(.N_IN(4), .DWELL(1), .MODE(0), .CNT_W(2))  u_sat  (.clk(clk), .rst(rst), .bus(buss));
   logic_vector_checker #(.N_IN(2), .DWELL(2), .MODE(3), .CNT_W(4))  u_nand (.clk(clk), .rst(rst), .bus(bus3));

   assign bus0.dut_out = (f0 == 2'd0) ? ~|bus0.vec_out : (f0 == 2'd1) ? 1'b0 : 1'b1;
   assign bus2.dut_out = (f2 == 2'd0) ?  &bus2.vec_out : (f2 == 2'd1) ? 1'b0 : 1'b1;
   assign buss.dut_out = (fs == 2'd0) ? ~|buss.vec_out : (fs == 2'd1) ? 1'b0 : 1'b1;
   assign bus3.dut_out = (f3 == 2'd0) ? ~&bus3.vec_out : (f3 == 2'd1) ? 1'b0 : 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_start(input int w, input logic v);
      case (w)
         0: bus0.start = v;
         1: bus2.start = v;
         2: buss.start = v;
         default: bus3.start = v;
      endcase
   endtask

   function automatic logic busy_of(input int w);
      case (w)
         0: return bus0.busy;
         1: return bus2.busy;
         2: return buss.busy;
         default: return bus3.busy;
      endcase
   endfunction

   // Pulse start for one edge, then count RUN clocks until busy drops.
   task automatic run(input int w, output int cycles);
      set_start(w, 1'b1);
      tick();
      set_start(w, 1'b0);
      cycles = 0;
      while (busy_of(w) && (cycles < 400)) begin
         tick();
         cycles++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      f0 = 2'd0; f2 = 2'd0; fs = 2'd0; f3 = 2'd0;
      bus0.start = 1'b0; bus2.start = 1'b0; buss.start = 1'b0; bus3.start = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_vec",  32'(bus0.vec_out), 32'h0);
      chk("rst_busy", 32'(bus0.busy), 32'h0);
      chk("rst_done", 32'(bus0.done), 32'h0);
      chk("rst_err",  32'(bus0.err_cnt), 32'h0);
      chk("rst_fvld", 32'(bus0.first_err_vld), 32'h0);
      chk("rst_fvec", 32'(bus0.first_err_vec), 32'h0);

      // 1: correct NOR gate, 16 vectors x 5 clocks
      run(0, cyc);
      chk("nor_ok_len",  32'(cyc), 32'd80);
      chk("nor_ok_done", 32'(bus0.done), 32'h1);
      chk("nor_ok_err",  32'(bus0.err_cnt), 32'h0);
      chk("nor_ok_fvld", 32'(bus0.first_err_vld), 32'h0);
      chk("nor_ok_vec",  32'(bus0.vec_out), 32'hF);
      tick(); tick(); tick();
      chk("nor_hold_done", 32'(bus0.done), 32'h1);
      chk("nor_hold_vec",  32'(bus0.vec_out), 32'hF);

      // 2: stuck-0 fails only at vector 0
      f0 = 2'd1;
      run(0, cyc);
      chk("nor_s0_err",  32'(bus0.err_cnt), 32'd1);
      chk("nor_s0_fvld", 32'(bus0.first_err_vld), 32'h1);
      chk("nor_s0_fvec", 32'(bus0.first_err_vec), 32'h0);

      // 3: stuck-1 fails at vectors 1..15; relaunch clears results and done
      f0 = 2'd2;
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
      chk("relaunch_done", 32'(bus0.done), 32'h0);
      chk("relaunch_busy", 32'(bus0.busy), 32'h1);
      chk("relaunch_err",  32'(bus0.err_cnt), 32'h0);
      chk("relaunch_fvld", 32'(bus0.first_err_vld), 32'h0);
      cyc = 0;
      while (bus0.busy && (cyc < 400)) begin
         tick();
         cyc++;
      end
      chk("nor_s1_len",  32'(cyc), 32'd80);
      chk("nor_s1_err",  32'(bus0.err_cnt), 32'd15);
      chk("nor_s1_fvec", 32'(bus0.first_err_vec), 32'h1);

      // 4: AND gate, correct then stuck-0 (fails only at 4'hF)
      run(1, cyc);
      chk("and_ok_err", 32'(bus2.err_cnt), 32'h0);
      chk("and_ok_done", 32'(bus2.done), 32'h1);
      f2 = 2'd1;
      run(1, cyc);
      chk("and_s0_err",  32'(bus2.err_cnt), 32'd1);
      chk("and_s0_fvec", 32'(bus2.first_err_vec), 32'hF);

      // 5: reset while vec_out==7 aborts the run with nothing retained
      f0 = 2'd2;
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
      cyc = 0;
      while ((bus0.vec_out != 4'h7) && (cyc < 400)) begin
         tick();
         cyc++;
      end
      chk("abort_reach7", 32'(bus0.vec_out), 32'h7);
      chk("abort_err_pre", 32'(bus0.err_cnt), 32'd6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_vec",  32'(bus0.vec_out), 32'h0);
      chk("abort_busy", 32'(bus0.busy), 32'h0);
      chk("abort_done", 32'(bus0.done), 32'h0);
      chk("abort_err",  32'(bus0.err_cnt), 32'h0);
      chk("abort_fvld", 32'(bus0.first_err_vld), 32'h0);
      chk("abort_fvec", 32'(bus0.first_err_vec), 32'h0);
      tick();
      chk("abort_idle", 32'(bus0.busy), 32'h0);
      f0 = 2'd0;
      run(0, cyc);
      chk("post_rst_len", 32'(cyc), 32'd80);
      chk("post_rst_err", 32'(bus0.err_cnt), 32'h0);
      chk("post_rst_done", 32'(bus0.done), 32'h1);

      // 6: start held high across the run: one full run, relaunch only from DONE
      bus0.start = 1'b1;
      tick();
      cyc = 0;
      while (bus0.busy && (cyc < 400)) begin
         tick();
         cyc++;
      end
      chk("held_len",  32'(cyc), 32'd80);
      chk("held_done", 32'(bus0.done), 32'h1);
      tick();
      chk("held_restart_busy", 32'(bus0.busy), 32'h1);
      chk("held_restart_done", 32'(bus0.done), 32'h0);
      chk("held_restart_vec",  32'(bus0.vec_out), 32'h0);
      bus0.start = 1'b0;
      cyc = 0;
      while (bus0.busy && (cyc < 400)) begin
         tick();
         cyc++;
      end
      chk("held_second_len", 32'(cyc), 32'd80);

      // 6b: DWELL=1, CNT_W=2, stuck-1 -> 15 mismatches saturate at 3
      fs = 2'd2;
      run(2, cyc);
      chk("sat_len",  32'(cyc), 32'd16);
      chk("sat_err",  32'(buss.err_cnt), 32'd3);
      chk("sat_fvld", 32'(buss.first_err_vld), 32'h1);
      chk("sat_fvec", 32'(buss.first_err_vec), 32'h1);

      // NAND, N_IN=2, DWELL=2: correct, stuck-1 (fails at 3), stuck-0 (fails at 0,1,2)
      run(3, cyc);
      chk("nand_ok_len", 32'(cyc), 32'd8);
      chk("nand_ok_err", 32'(bus3.err_cnt), 32'h0);
      f3 = 2'd2;
      run(3, cyc);
      chk("nand_s1_err",  32'(bus3.err_cnt), 32'd1);
      chk("nand_s1_fvec", 32'(bus3.first_err_vec), 32'h3);
      f3 = 2'd1;
      run(3, cyc);
      chk("nand_s0_err",  32'(bus3.err_cnt), 32'd3);
      chk("nand_s0_fvec", 32'(bus3.first_err_vec), 32'h0);
      chk("nand_s0_vec",  32'(bus3.vec_out), 32'h3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
